regfile_port_scheduler: RTL and testbench

- Arbitrates the register file's single write port and paired read port between a writeback requester (writes) and a decode requester (two-operand reads).
- Sits between the pipeline and the register file and drives every register file port.
- Enforces the register file's timing:
  - read data is registered one cycle after the address is presented;
  - the read registers are not updated in a write cycle.
- Returns captured operands through a valid/ready response channel, with bounded read starvation.

---
 rtl/regfile_port_scheduler.sv | 113 +++++++++++
 tb/tb_regfile_port_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_scheduler.sv
// Schedules the register file's single write port and paired read port between
// writeback (writes) and decode (two-operand reads), returning operands on a valid/ready channel.
module regfile_port_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_address,
    input  logic [31:0] wr_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [4:0]  rd_address1,
    input  logic [4:0]  rd_address2,
    output logic        rd_resp_valid,
    input  logic        rd_resp_ready,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    output logic [4:0]  rf_read_address1,
    output logic [4:0]  rf_read_address2,
    output logic [4:0]  rf_write_address,
    output logic [31:0] rf_write_data,
    output logic        rf_write_enable,
    input  logic [31:0] rf_read_data1,
    input  logic [31:0] rf_read_data2
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        RESP
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    logic [3:0]  starve_cnt;
    logic [4:0]  lat_addr1;
    logic [4:0]  lat_addr2;
    logic [31:0] data1_q;
    logic [31:0] data2_q;

    logic issue_window;
    logic wr_consumes;
    logic rd_accept;
    logic wr_accept;
    logic starve_inc;

    // NOTE: every signal gets a value before any condition, so no path leaves one unassigned (no latch).
    always_comb begin
        issue_window = 1'b0;
        wr_consumes  = 1'b0;
        rd_accept    = 1'b0;
        wr_accept    = 1'b0;
        starve_inc   = 1'b0;

        issue_window = (state == IDLE) || ((state == RESP) && rd_resp_ready);
        // A write to x0 never touches the port, so it cannot block a read.
        wr_consumes  = wr_valid && (wr_address != 5'd0);
        rd_accept    = issue_window && rd_valid && (!wr_consumes || (starve_cnt == LIMIT));
        wr_accept    = wr_valid && !(rd_accept && wr_consumes);
        starve_inc   = issue_window && rd_valid && wr_consumes && (starve_cnt != LIMIT);
    end

    assign wr_ready         = wr_accept;
    assign rd_ready         = rd_accept;
    assign rd_resp_valid    = (state == RESP);
    assign rd_data1         = data1_q;
    assign rd_data2         = data2_q;
    assign rf_write_enable  = wr_accept && wr_consumes;
    assign rf_write_address = wr_address;
    assign rf_write_data    = wr_data;
    assign rf_read_address1 = rd_accept ? rd_address1 : lat_addr1;
    assign rf_read_address2 = rd_accept ? rd_address2 : lat_addr2;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            lat_addr1  <= 5'd0;
            lat_addr2  <= 5'd0;
            data1_q    <= 32'd0;
            data2_q    <= 32'd0;
        end else begin
            if (rd_accept) begin
                lat_addr1  <= rd_address1;
                lat_addr2  <= rd_address2;
                starve_cnt <= 4'd0;
            end else if (starve_inc) begin
                starve_cnt <= starve_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (rd_accept) state <= FETCH;
                end
                FETCH: begin
                    // Read registers were loaded in the issue cycle and frozen by any write since.
                    data1_q <= rf_read_data1;
                    data2_q <= rf_read_data2;
                    state   <= RESP;
                end
                RESP: begin
                    if (rd_resp_ready) state <= rd_accept ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a behavioural register file whose
// read registers load one cycle after the address and hold during write cycles.
module tb_regfile_port_scheduler;

    logic        clk;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_address;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_address1;
    logic [4:0]  rd_address2;
    logic        rd_resp_valid;
    logic        rd_resp_ready;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [4:0]  rf_read_address1;
    logic [4:0]  rf_read_address2;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_write_data;
    logic        rf_write_enable;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf_mem [32];

    regfile_port_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_address       (wr_address),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .rd_address1      (rd_address1),
        .rd_address2      (rd_address2),
        .rd_resp_valid    (rd_resp_valid),
        .rd_resp_ready    (rd_resp_ready),
        .rd_data1         (rd_data1),
        .rd_data2         (rd_data2),
        .rf_read_address1 (rf_read_address1),
        .rf_read_address2 (rf_read_address2),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_write_enable  (rf_write_enable),
        .rf_read_data1    (rf_read_data1),
        .rf_read_data2    (rf_read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: x0 reads as zero; read registers hold in a write cycle.
    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_read_data1 = 32'd0;
        rf_read_data2 = 32'd0;
    end

    always @(posedge clk) begin
        if (rf_write_enable) begin
            rf_mem[rf_write_address] <= rf_write_data;
        end else begin
            rf_read_data1 <= (rf_read_address1 == 5'd0) ? 32'd0 : rf_mem[rf_read_address1];
            rf_read_data2 <= (rf_read_address2 == 5'd0) ? 32'd0 : rf_mem[rf_read_address2];
        end
    end

    task automatic settle();
        @(negedge clk);
        wr_valid      = 1'b0;
        rd_valid      = 1'b0;
        rd_resp_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Issue one read with an always-ready consumer; ok=0 if not accepted or no response.
    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2,
                           output logic [31:0] d1, output logic [31:0] d2, output bit ok);
        bit acc;
        acc = 1'b0;
        ok  = 1'b0;
        d1  = 32'd0;
        d2  = 32'd0;
        @(negedge clk);
        wr_valid      = 1'b0;
        rd_valid      = 1'b1;
        rd_address1   = a1;
        rd_address2   = a2;
        rd_resp_ready = 1'b1;
        for (int i = 0; i < 16 && !acc; i++) begin
            #1;
            if (rd_ready === 1'b1) acc = 1'b1;
            else @(negedge clk);
        end
        if (acc) begin
            @(negedge clk);
            rd_valid = 1'b0;
            @(negedge clk);
            #1;
            ok = (rd_resp_valid === 1'b1);
            d1 = rd_data1;
            d2 = rd_data2;
        end else begin
            rd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        wr_valid      = 1'b0;
        wr_address    = 5'd0;
        wr_data       = 32'd0;
        rd_valid      = 1'b0;
        rd_address1   = 5'd0;
        rd_address2   = 5'd0;
        rd_resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", rd_resp_valid); end
        n_checks++;
        if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", rd_data1, rd_data2);
        end
        n_checks++;
        if (rf_read_address1 !== 5'd0 || rf_write_enable !== 1'b0 || wr_ready !== 1'b0 || rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ports: addr1 %h we %b wr_ready %b rd_ready %b want 0", rf_read_address1, rf_write_enable, wr_ready, rd_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        settle();
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        wr_valid = 1'b1; wr_address = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || rf_write_enable !== 1'b1) begin
            n_fail++; $display("FAIL wr_accept: wr_ready %b we %b want 1/1", wr_ready, rf_write_enable);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_address1 = 5'd5; rd_address2 = 5'd0; rd_resp_ready = 1'b1;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1 || rf_read_address1 !== 5'd5 || rf_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL rd_issue: rd_ready %b addr1 %h we %b want 1/05/0", rd_ready, rf_read_address1, rf_write_enable);
        end
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b0 || rf_read_address1 !== 5'd5) begin
            n_fail++; $display("FAIL fetch_state: resp_valid %b addr1 %h want 0/05", rd_resp_valid, rf_read_address1);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_data1 !== 32'hDEADBEEF || rd_data2 !== 32'd0) begin
            n_fail++; $display("FAIL read_x5: valid %b data %h/%h want 1 deadbeef/0", rd_resp_valid, rd_data1, rd_data2);
        end
        settle();
    endtask

    task automatic test_write_wins();
        @(negedge clk);
        rd_valid = 1'b1; rd_address1 = 5'd5; rd_address2 = 5'd6; rd_resp_ready = 1'b1;
        wr_valid = 1'b1; wr_address = 5'd5; wr_data = 32'h11;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL write_wins: wr_ready %b rd_ready %b want 1/0", wr_ready, rd_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1 || rf_read_address1 !== 5'd5 || rf_read_address2 !== 5'd6) begin
            n_fail++; $display("FAIL read_next: rd_ready %b addr %h/%h want 1 05/06", rd_ready, rf_read_address1, rf_read_address2);
        end
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_data1 !== 32'h11 || rd_data2 !== 32'd0) begin
            n_fail++; $display("FAIL read_after_write: valid %b data %h/%h want 1 11/0", rd_resp_valid, rd_data1, rd_data2);
        end
        settle();
    endtask

    task automatic test_starvation();
        @(negedge clk);
        rd_valid = 1'b1; rd_address1 = 5'd1; rd_address2 = 5'd2; rd_resp_ready = 1'b1;
        wr_valid = 1'b1; wr_address = 5'd3;
        for (int k = 0; k < 4; k++) begin
            wr_data = 32'h100 + 32'(k);
            #1;
            n_checks++;
            if (wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
                n_fail++; $display("FAIL starve_write%0d: wr_ready %b rd_ready %b want 1/0", k, wr_ready, rd_ready);
            end
            @(negedge clk);
        end
        wr_data = 32'h104;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1 || wr_ready !== 1'b0 || rf_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL starve_forced: rd_ready %b wr_ready %b we %b want 1/0/0", rd_ready, wr_ready, rf_write_enable);
        end
        @(negedge clk);
        rd_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        rd_valid = 1'b1; rd_address1 = 5'd3; rd_address2 = 5'd4;
        wr_valid = 1'b1; wr_address = 5'd4; wr_data = 32'h55;
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || wr_ready !== 1'b1 || rd_ready !== 1'b0) begin
            n_fail++; $display("FAIL starve_cleared: resp %b wr_ready %b rd_ready %b want 1/1/0", rd_resp_valid, wr_ready, rd_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL starve_retry: rd_ready %b want 1", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_data1 !== 32'h103 || rd_data2 !== 32'h55) begin
            n_fail++; $display("FAIL starve_data: valid %b data %h/%h want 1 103/55", rd_resp_valid, rd_data1, rd_data2);
        end
        settle();
    endtask

    task automatic test_write_during_fetch();
        logic [31:0] d1, d2;
        bit ok;
        @(negedge clk);
        wr_valid = 1'b1; wr_address = 5'd7; wr_data = 32'h33;
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_address1 = 5'd7; rd_address2 = 5'd7; rd_resp_ready = 1'b1;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_issue: rd_ready %b want 1", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0;
        wr_valid = 1'b1; wr_address = 5'd7; wr_data = 32'h22;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || rf_write_enable !== 1'b1) begin
            n_fail++; $display("FAIL fetch_write: wr_ready %b we %b want 1/1", wr_ready, rf_write_enable);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_data1 !== 32'h33 || rd_data2 !== 32'h33) begin
            n_fail++; $display("FAIL fetch_old_data: valid %b data %h/%h want 1 33/33", rd_resp_valid, rd_data1, rd_data2);
        end
        do_read(5'd7, 5'd7, d1, d2, ok);
        n_checks++;
        if (!ok || d1 !== 32'h22 || d2 !== 32'h22) begin
            n_fail++; $display("FAIL fetch_new_data: ok %b data %h/%h want 1 22/22", ok, d1, d2);
        end
        settle();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rd_valid = 1'b1; rd_address1 = 5'd7; rd_address2 = 5'd0; rd_resp_ready = 1'b0;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_issue: rd_ready %b want 1", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rd_valid = 1'b1; rd_address1 = 5'd1; rd_address2 = 5'd1;
            wr_valid = 1'b1; wr_address = 5'd7; wr_data = 32'h40 + 32'(i);
            #1;
            n_checks++;
            if (rd_resp_valid !== 1'b1 || rd_data1 !== 32'h22 || rd_data2 !== 32'd0 || rd_ready !== 1'b0 || wr_ready !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold%0d: valid %b data %h/%h rd_ready %b wr_ready %b want 1 22/0 0 1", i, rd_resp_valid, rd_data1, rd_data2, rd_ready, wr_ready);
            end
            @(negedge clk);
        end
        wr_valid = 1'b0; rd_resp_ready = 1'b1;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1 || rd_resp_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: rd_ready %b resp %b want 1/1", rd_ready, rd_resp_valid);
        end
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_data1 !== 32'd0) begin
            n_fail++; $display("FAIL bp_next_read: valid %b data1 %h want 1/0", rd_resp_valid, rd_data1);
        end
        settle();
    endtask

    task automatic test_x0_write();
        logic [31:0] d1, d2;
        bit ok;
        @(negedge clk);
        rd_valid = 1'b1; rd_address1 = 5'd0; rd_address2 = 5'd5; rd_resp_ready = 1'b1;
        wr_valid = 1'b1; wr_address = 5'd0; wr_data = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1 || rd_ready !== 1'b1 || rf_write_enable !== 1'b0) begin
            n_fail++; $display("FAIL x0_concurrent: wr_ready %b rd_ready %b we %b want 1/1/0", wr_ready, rd_ready, rf_write_enable);
        end
        @(negedge clk);
        rd_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_data1 !== 32'd0 || rd_data2 !== 32'h11) begin
            n_fail++; $display("FAIL x0_data: valid %b data %h/%h want 1 0/11", rd_resp_valid, rd_data1, rd_data2);
        end
        do_read(5'd0, 5'd0, d1, d2, ok);
        n_checks++;
        if (!ok || d1 !== 32'd0 || d2 !== 32'd0) begin
            n_fail++; $display("FAIL x0_read: ok %b data %h/%h want 1 0/0", ok, d1, d2);
        end
        settle();
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] d1, d2;
        bit ok;
        do_read(5'd5, 5'd5, d1, d2, ok);
        n_checks++;
        if (!ok || d1 !== 32'h11) begin n_fail++; $display("FAIL pre_reset_read: ok %b data1 %h want 1/11", ok, d1); end
        settle();
        rd_valid = 1'b1; rd_address1 = 5'd5; rd_address2 = 5'd5;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue: rd_ready %b want 1", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (rd_resp_valid !== 1'b0 || rd_data1 !== 32'd0 || rf_read_address1 !== 5'd0) begin
            n_fail++; $display("FAIL reset_mid: valid %b data1 %h addr1 %h want 0/0/00", rd_resp_valid, rd_data1, rf_read_address1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (rd_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_resp%0d: valid %b want 0", i, rd_resp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_write_wins();
        test_starvation();
        test_write_during_fetch();
        test_backpressure();
        test_x0_write();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
